// File: rtl/router_pkg.sv
// router_pkg: shared allocator types and router port count.
package router_pkg;
    localparam int NUM_PORTS = 5;
    typedef enum logic [2:0] {IDLE, ARB, REQ, XFER, REL} alloc_state_t;
    typedef logic [$clog2(NUM_PORTS)-1:0] alloc_sel_t;
endpackage

// File: rtl/output_port_allocator_if.sv
// output_port_allocator_if: switch request, crossbar select and downstream handshake bundle.
interface output_port_allocator_if
    import router_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_PORTS
);
    logic [NUM_INPUTS-1:0] i_switch_req, o_switch_ack, o_grant;
    logic [$clog2(NUM_INPUTS)-1:0] o_sel;
    logic i_flit_valid, i_flit_tail, i_transmit_ack;
    logic o_transmit_req, o_busy, o_timeout;
    modport master (
        output i_switch_req, i_flit_valid, i_flit_tail, i_transmit_ack,
        input  o_switch_ack, o_grant, o_sel, o_transmit_req, o_busy, o_timeout
    );
    modport slave (
        input  i_switch_req, i_flit_valid, i_flit_tail, i_transmit_ack,
        output o_switch_ack, o_grant, o_sel, o_transmit_req, o_busy, o_timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = |req;
        // Scan farthest offset first so the nearest request to ptr is the last write.
        for (int k = N - 1; k >= 0; k--) begin
            automatic int j = (int'(ptr) + k) % N;
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = W'(j);
            end
        end
    end
endmodule

// File: rtl/output_port_allocator.sv
// output_port_allocator: round-robin switch allocator for one crossbar output port.
// Define ALLOC_TIMEOUT_EN to abort the downstream handshake after TIMEOUT_CYC cycles.
module output_port_allocator
    import router_pkg::*;
#(
    parameter int NUM_INPUTS  = NUM_PORTS,
    parameter int PKT_FLITS   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input logic clk,
    input logic reset,
    output_port_allocator_if.slave bus
);
    localparam int SW = $clog2(NUM_INPUTS);
    localparam int CW = $clog2(PKT_FLITS + 1);
    alloc_state_t state;
    logic [SW-1:0] rr_ptr, arb_idx, next_ptr;
    logic [NUM_INPUTS-1:0] arb_gnt;
    logic arb_any;
    logic [CW-1:0] flit_cnt;

    rr_arbiter #(.N(NUM_INPUTS)) u_arb (
        .req(bus.i_switch_req),
        .ptr(rr_ptr),
        .gnt(arb_gnt),
        .idx(arb_idx),
        .any(arb_any)
    );

    // Previous winner drops to lowest priority.
    assign next_ptr = (bus.o_sel == SW'(NUM_INPUTS - 1)) ? '0 : bus.o_sel + SW'(1);

`ifdef ALLOC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
`else
    assign bus.o_timeout = 1'b0 && (TIMEOUT_CYC > 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            flit_cnt           <= '0;
            bus.o_switch_ack   <= '0;
            bus.o_grant        <= '0;
            bus.o_sel          <= '0;
            bus.o_transmit_req <= 1'b0;
            bus.o_busy         <= 1'b0;
`ifdef ALLOC_TIMEOUT_EN
            bus.o_timeout      <= 1'b0;
            wait_cnt           <= '0;
`endif
        end else begin
            bus.o_switch_ack <= '0;
`ifdef ALLOC_TIMEOUT_EN
            bus.o_timeout    <= 1'b0;
`endif
            case (state)
                IDLE: if (|bus.i_switch_req) begin
                    state      <= ARB;
                    bus.o_busy <= 1'b1;
                end
                ARB: if (arb_any) begin
                    state              <= REQ;
                    bus.o_grant        <= arb_gnt;
                    bus.o_sel          <= arb_idx;
                    bus.o_transmit_req <= 1'b1;
`ifdef ALLOC_TIMEOUT_EN
                    wait_cnt           <= '0;
`endif
                end else begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
                REQ: if (bus.i_transmit_ack) begin
                    state              <= XFER;
                    bus.o_switch_ack   <= bus.o_grant;
                    bus.o_transmit_req <= 1'b0;
                    flit_cnt           <= '0;
                end
`ifdef ALLOC_TIMEOUT_EN
                else if (wait_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    state              <= REL;
                    bus.o_timeout      <= 1'b1;
                    bus.o_grant        <= '0;
                    bus.o_transmit_req <= 1'b0;
                    rr_ptr             <= next_ptr;
                end else wait_cnt <= wait_cnt + TW'(1);
`endif
                XFER: if (bus.i_flit_valid) begin
                    flit_cnt <= flit_cnt + CW'(1);
                    if (bus.i_flit_tail || flit_cnt == CW'(PKT_FLITS - 1)) begin
                        state       <= REL;
                        bus.o_grant <= '0;
                        rr_ptr      <= next_ptr;
                    end
                end
                REL: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_output_port_allocator.sv
// tb_output_port_allocator: directed scoreboard bench for output_port_allocator.
module tb_output_port_allocator;
    import router_pkg::*;
    localparam int N = NUM_PORTS;
    localparam int EV_ACK = 0, EV_REL = 1, EV_TO = 2;
    typedef struct packed {
        logic [1:0]   kind;
        logic [N-1:0] vec;
        alloc_sel_t   sel;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    output_port_allocator_if #(.NUM_INPUTS(N)) bus ();
    output_port_allocator dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0, fails = 0;
    ev_t exp_q[$];
    logic [N-1:0] prev_grant = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_event(input int kind, input int vec, input int sel);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected event kind", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        check("event kind", kind, int'(e.kind));
        check("event vector", vec, int'(e.vec));
        check("event sel", sel, int'(e.sel));
    endtask

    // Monitor: ack pulses, grant releases and timeouts are matched in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.o_timeout)
                expect_event(EV_TO, int'(prev_grant), int'(bus.o_sel));
            else if (prev_grant != '0 && bus.o_grant == '0)
                expect_event(EV_REL, int'(prev_grant), int'(bus.o_sel));
            if (bus.o_switch_ack != '0)
                expect_event(EV_ACK, int'(bus.o_switch_ack), int'(bus.o_sel));
        end
        prev_grant = bus.o_grant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [N-1:0] vec, input int sel);
        ev_t e;
        e.kind = 2'(kind);
        e.vec  = vec;
        e.sel  = alloc_sel_t'(sel);
        exp_q.push_back(e);
    endtask

    task automatic wait_treq(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.o_transmit_req && n < 40);
        check("transmit_req within budget", int'(bus.o_transmit_req), 1);
    endtask

    task automatic run_pkt(input logic [N-1:0] req, mid, after, exp_vec,
                           input int exp_sel, ack_dly, flits, input bit tail, output int lat);
        bus.i_switch_req = req;
        push(EV_ACK, exp_vec, exp_sel);
        push(EV_REL, exp_vec, exp_sel);
        wait_treq(lat);
        bus.i_switch_req = mid;
        check("grant in REQ", int'(bus.o_grant), int'(exp_vec));
        check("sel in REQ", int'(bus.o_sel), exp_sel);
        repeat (ack_dly) tick();
        check("grant held at ack", int'(bus.o_grant), int'(exp_vec));
        bus.i_transmit_ack = 1'b1;
        tick();
        bus.i_transmit_ack = 1'b0;
        bus.i_switch_req = after;
        check("transmit_req drops", int'(bus.o_transmit_req), 0);
        for (int i = 0; i < flits; i++) begin
            bus.i_flit_valid = 1'b1;
            bus.i_flit_tail  = tail && (i == flits - 1);
            tick();
        end
        bus.i_flit_valid = 1'b0;
        bus.i_flit_tail  = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_switch_req = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int lat;
        bus.i_switch_req   = '0;
        bus.i_flit_valid   = 1'b0;
        bus.i_flit_tail    = 1'b0;
        bus.i_transmit_ack = 1'b0;
        do_reset();
        check("reset grant", int'(bus.o_grant), 0);
        check("reset sel", int'(bus.o_sel), 0);
        check("reset transmit_req", int'(bus.o_transmit_req), 0);
        check("reset busy", int'(bus.o_busy), 0);
        check("reset timeout", int'(bus.o_timeout), 0);

        // Single requester, ack two cycles into REQ, tail on flit 3.
        run_pkt(5'b00100, 5'b00100, 5'b0, 5'b00100, 2, 2, 3, 1'b1, lat);
        check("first latency", lat, 2);
        check("grant cleared in REL", int'(bus.o_grant), 0);
        check("busy in REL", int'(bus.o_busy), 1);
        tick();
        check("idle after REL", int'(bus.o_busy), 0);
        // Pointer is now 3: index 3 beats index 0.
        run_pkt(5'b01001, 5'b01001, 5'b0, 5'b01000, 3, 0, 1, 1'b1, lat);
        tick();

        // All requesting from pointer 0: rotation 0..4, 3-cycle turnaround.
        do_reset();
        for (int k = 0; k < N; k++) begin
            run_pkt(5'b11111, 5'b11111, (k == N - 1) ? 5'b0 : 5'b11111,
                    N'(1 << k), k, 0, 4, 1'b1, lat);
            check("turnaround latency", lat, (k == 0) ? 2 : 3);
        end

        // Missing tail: forced release after 4 flits, 5th flit ignored.
        run_pkt(5'b00010, 5'b00010, 5'b0, 5'b00010, 1, 0, 4, 1'b0, lat);
        check("forced release grant", int'(bus.o_grant), 0);
        check("forced release busy", int'(bus.o_busy), 1);
        bus.i_flit_valid = 1'b1;
        tick();
        bus.i_flit_valid = 1'b0;
        check("extra flit grant", int'(bus.o_grant), 0);
        check("extra flit busy", int'(bus.o_busy), 0);

        // Winner 2 drops its request during REQ; grant holds, then 3 wins.
        run_pkt(5'b11111, 5'b11011, 5'b11011, 5'b00100, 2, 1, 2, 1'b1, lat);
        run_pkt(5'b11011, 5'b11011, 5'b0, 5'b01000, 3, 0, 1, 1'b1, lat);
        check("latency after drop", lat, 3);
        tick();

        // Reset in XFER with two flits counted; pointer restarts at 0.
        bus.i_switch_req = 5'b00100;
        push(EV_ACK, 5'b00100, 2);
        wait_treq(lat);
        bus.i_transmit_ack = 1'b1;
        tick();
        bus.i_transmit_ack = 1'b0;
        bus.i_switch_req = '0;
        bus.i_flit_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("async reset grant", int'(bus.o_grant), 0);
        check("async reset sel", int'(bus.o_sel), 0);
        check("async reset switch_ack", int'(bus.o_switch_ack), 0);
        check("async reset transmit_req", int'(bus.o_transmit_req), 0);
        check("async reset busy", int'(bus.o_busy), 0);
        check("async reset timeout", int'(bus.o_timeout), 0);
        bus.i_flit_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_pkt(5'b10001, 5'b10001, 5'b0, 5'b00001, 0, 0, 1, 1'b1, lat);
        check("latency after reset", lat, 2);
        tick();

`ifdef ALLOC_TIMEOUT_EN
        // No ack: timeout pulse after 16 REQ cycles, no switch ack.
        bus.i_switch_req = 5'b00010;
        push(EV_TO, 5'b00010, 1);
        wait_treq(lat);
        repeat (15) tick();
        check("still waiting at cycle 16", int'(bus.o_transmit_req), 1);
        check("no early timeout", int'(bus.o_timeout), 0);
        tick();
        bus.i_switch_req = '0;
        check("timeout pulse", int'(bus.o_timeout), 1);
        check("timeout no switch_ack", int'(bus.o_switch_ack), 0);
        check("timeout grant cleared", int'(bus.o_grant), 0);
        tick();
        check("timeout one cycle", int'(bus.o_timeout), 0);
        // Ack on the 16th cycle wins over the timeout.
        run_pkt(5'b00100, 5'b00100, 5'b0, 5'b00100, 2, 15, 1, 1'b1, lat);
        check("late ack no timeout", int'(bus.o_timeout), 0);
`else
        // Without the timeout feature REQ waits as long as needed.
        run_pkt(5'b00010, 5'b00010, 5'b0, 5'b00010, 1, 20, 1, 1'b1, lat);
        check("no timeout output", int'(bus.o_timeout), 0);
`endif
        repeat (4) tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
